// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; one-cycle latency, in_ready drops only when full.
// Flush empties the queue at the next edge. Define PFQ_BYPASS_EN for zero-latency bypass when empty.
module inst_prefetch_queue #(
   parameter int INST_ADDR_WIDTH     = 16,
   parameter int INST_DATA_BIT_WIDTH = 16,
   parameter int DEPTH               = 4,
   parameter int PTR_WIDTH           = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [INST_ADDR_WIDTH-1:0]     in_pc,
   input  logic [INST_DATA_BIT_WIDTH-1:0] in_inst,
   input  logic                           in_exc,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INST_ADDR_WIDTH-1:0]     out_pc,
   output logic [INST_DATA_BIT_WIDTH-1:0] out_inst,
   output logic                           out_exc,
   output logic [PTR_WIDTH:0]             count
);

   typedef struct packed {
      logic [INST_ADDR_WIDTH-1:0]     pc;
      logic [INST_DATA_BIT_WIDTH-1:0] inst;
      logic                           exc;
   } entry_t;

   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

   entry_t               mem_q [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;

   entry_t in_ent;
   entry_t out_ent;
   logic   empty, full;
   logic   push, pop;
   logic   wr_en, rd_en;

   assign in_ent = '{pc: in_pc, inst: in_inst, exc: in_exc};
   assign empty  = (count_q == '0);
   assign full   = (count_q == FULL_CNT);

   // in_ready ignores out_ready: no push-through when full.
   assign in_ready = rst & ~full;
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;

`ifdef PFQ_BYPASS_EN
   logic bypass;
   // An empty queue forwards the incoming tuple; it is stored only if decode stalls.
   assign bypass    = rst & empty & in_valid & ~flush;
   assign out_valid = ~empty | bypass;
   assign out_ent   = bypass ? in_ent : (empty ? '0 : mem_q[rd_ptr_q]);
   assign wr_en     = push & ~(bypass & out_ready);
   assign rd_en     = pop & ~bypass;
`else
   assign out_valid = ~empty;
   assign out_ent   = empty ? '0 : mem_q[rd_ptr_q];
   assign wr_en     = push;
   assign rd_en     = pop;
`endif

   assign out_pc   = out_ent.pc;
   assign out_inst = out_ent.inst;
   assign out_exc  = out_ent.exc;
   assign count    = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; count gates everything read from it.
   always_ff @(posedge clk) begin
      if (wr_en && !flush) mem_q[wr_ptr_q] <= in_ent;
   end

endmodule
